alu_serial_ctrl: RTL

- Bit-serial ALU sequencer: one alu_1bit slice is instantiated internally and time-shared over all WIDTH operand bits, LSB first.
- Provides a start/done handshake, per-op carry and SLT sequencing, and flag generation.
- Serves as a low-area multi-cycle ALU for the datapath, in place of a WIDTH-slice ripple array.

---
 rtl/alu_serial_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_serial_ctrl : bit-serial ALU sequencer around one time-shared slice   |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+

module alu_1bit (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       c_in_i,
   input  logic       less_i,
   input  logic [2:0] op_i,
   output logic       r_o,
   output logic       c_out_o,
   output logic       set_o
);
   logic w_bb;
   logic w_sum;

   assign w_bb    = b_i ^ op_i[2];
   assign w_sum   = a_i ^ w_bb ^ c_in_i;
   assign c_out_o = (a_i & w_bb) | (a_i & c_in_i) | (w_bb & c_in_i);
   assign set_o   = w_sum;

   always_comb begin
      r_o = 1'b0;
      case (op_i[1:0])
         2'b00:   r_o = a_i & w_bb;
         2'b01:   r_o = a_i | w_bb;
         2'b10:   r_o = w_sum;
         default: r_o = less_i;
      endcase
   end
endmodule

module alu_serial_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow,
   output logic             zero,
   output logic             err
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             busy_q, done_q, c_out_q, ovf_q, zero_q, err_q;
   logic [WIDTH-1:0] result_q;

   logic             w_r, w_cout, w_set, w_last;
   logic [WIDTH-1:0] w_res_full;
   logic [WIDTH-1:0] result_d;
   logic             c_out_d, ovf_d, err_d, w_ovf;

   alu_1bit u_slice (
      .a_i     (a_sh_q[0]),
      .b_i     (b_sh_q[0]),
      .c_in_i  (carry_q),
      .less_i  (1'b0),
      .op_i    (op_q),
      .r_o     (w_r),
      .c_out_o (w_cout),
      .set_o   (w_set)
   );

   assign w_last     = (cnt_q == CNT_W'(WIDTH - 1));
   assign w_res_full = {w_r, res_sh_q[WIDTH-1:1]};
   // On the MSB cycle carry_q is the carry into the MSB.
   assign w_ovf      = carry_q ^ w_cout;

   always_comb begin
      result_d = '0;
      c_out_d  = 1'b0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            result_d = w_res_full;
            c_out_d  = w_cout;
            ovf_d    = w_ovf;
         end
         OP_SLT: begin
            result_d = {{(WIDTH-1){1'b0}}, w_set ^ w_ovf};
            c_out_d  = w_cout;
            ovf_d    = w_ovf;
         end
         OP_AND, OP_OR: result_d = w_res_full;
         default:       err_d    = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_sh_q   <= a;
                  b_sh_q   <= b;
                  op_q     <= op;
                  cnt_q    <= '0;
                  carry_q  <= op[2];
                  res_sh_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_RUN;
               end else begin
                  state_q  <= S_IDLE;
               end
            end
            S_RUN: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               res_sh_q <= w_res_full;
               carry_q  <= w_cout;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (w_last) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= result_d;
                  c_out_q  <= c_out_d;
                  ovf_q    <= ovf_d;
                  zero_q   <= (result_d == '0);
                  err_q    <= err_d;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
   assign err      = err_q;
endmodule
`default_nettype wire
